// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder
// Codec-side I2C write target modelled on the WM8731 control port. Receives
// [DEV_ADDR,W] [reg[6:0],data[8]] [data[7:0]] frames, acknowledges each byte
// and reports each completed register write as a one-cycle strobe.
// Optional feature macro: I2C_RESP_GLITCH_FILTER_EN adds a 3-sample majority
// filter after the synchronizers (detection latency 5 cycles instead of 3).
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        BYTE1  = 3'd3,
        ACK_1  = 3'd4,
        BYTE2  = 3'd5,
        ACK_2  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through the input conditioning.
    logic [1:0] pin_w;
    logic [1:0] line_w;
    logic [1:0] prev_q;

    assign pin_w = {i_sda, i_scl};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic s1_q;
            logic s2_q;

            // Two-flop synchronizer; resets to the idle-bus level.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    s1_q <= 1'b1;
                    s2_q <= 1'b1;
                end else begin
                    s1_q <= pin_w[gi];
                    s2_q <= s1_q;
                end
            end

`ifdef I2C_RESP_GLITCH_FILTER_EN
            logic [2:0] hist_q;

            // Three-sample history feeding the majority vote.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    hist_q <= 3'b111;
                end else begin
                    hist_q <= {hist_q[1:0], s2_q};
                end
            end

            assign line_w[gi] = (hist_q[0] & hist_q[1]) |
                                (hist_q[0] & hist_q[2]) |
                                (hist_q[1] & hist_q[2]);
`else
            assign line_w[gi] = s2_q;
`endif
        end
    endgenerate

    // Previous conditioned level of SCL/SDA for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= 2'b11;
        end else begin
            prev_q <= line_w;
        end
    end

    logic scl_w, sda_w, scl_prev_w, sda_prev_w;
    logic start_w, stop_w, scl_rise_w, scl_fall_w;
    logic committed_w;

    assign scl_w      = line_w[0];
    assign sda_w      = line_w[1];
    assign scl_prev_w = prev_q[0];
    assign sda_prev_w = prev_q[1];

    // START/STOP require SCL high on both samples so an SDA move around an
    // SCL edge is never mistaken for a bus condition.
    assign start_w    = scl_w & scl_prev_w & sda_prev_w & ~sda_w;
    assign stop_w     = scl_w & scl_prev_w & ~sda_prev_w & sda_w;
    assign scl_rise_w = scl_w & ~scl_prev_w;
    assign scl_fall_w = ~scl_w & scl_prev_w;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  byte1_q, byte1_d;
    logic        valid_q, valid_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [8:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    // Address has been acknowledged but the write is not yet committed.
    assign committed_w = (state_q == BYTE1) || (state_q == ACK_1) ||
                         (state_q == BYTE2) || (state_q == ACK_2);

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            done_q    <= 1'b0;
            shreg_q   <= 8'd0;
            byte1_q   <= 8'd0;
            valid_q   <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 9'd0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            shreg_q   <= shreg_d;
            byte1_q   <= byte1_d;
            valid_q   <= valid_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: bus conditions first, then bit shifting and ACK slots.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        shreg_d   = shreg_q;
        byte1_d   = byte1_q;
        valid_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        err_d     = 1'b0;

        if (start_w) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            err_d   = committed_w;
        end else if (stop_w) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            err_d   = committed_w;
        end else begin
            case (state_q)
                ADDR, BYTE1, BYTE2: begin
                    if (scl_rise_w && !done_q) begin
                        shreg_d = {shreg_q[6:0], sda_w};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            done_d = 1'b1;
                        end
                    end else if (scl_fall_w && done_q) begin
                        // Eighth bit is complete: the falling edge opens the ACK slot.
                        done_d = 1'b0;
                        cnt_d  = 3'd0;
                        case (state_q)
                            ADDR:    state_d = (shreg_q == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                            BYTE1: begin
                                byte1_d = shreg_q;
                                state_d = ACK_1;
                            end
                            default: state_d = ACK_2;
                        endcase
                    end
                end
                ACK_A: begin
                    if (scl_fall_w) begin
                        state_d = BYTE1;
                    end
                end
                ACK_1: begin
                    if (scl_fall_w) begin
                        state_d = BYTE2;
                    end
                end
                ACK_2: begin
                    if (scl_fall_w) begin
                        valid_d   = 1'b1;
                        wr_addr_d = byte1_q[7:1];
                        wr_data_d = {byte1_q[0], shreg_q};
                        state_d   = IGNORE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // SDA is pulled low only while in an ACK slot; async reset releases it at once.
    assign o_sda_oen  = (state_q == ACK_A) || (state_q == ACK_1) || (state_q == ACK_2);
    assign o_wr_valid = valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: drives I2C write frames with a
// slow bit-banged master and checks ACKs, commit strobes and status outputs.
module tb_i2c_codec_responder;

    localparam int Q = 10; // i_clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oen;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    // Monitor state
    int         valid_cnt = 0;
    int         valid_run = 0;
    int         valid_max_run = 0;
    int         err_cnt = 0;
    int         oen_cycles = 0;
    int         busy_rises = 0;
    logic       busy_prev = 1'b0;
    logic [6:0] cap_addr = 7'd0;
    logic [8:0] cap_data = 9'd0;

    assign sda_bus = sda_m & ~sda_oen;

    always #5 clk = ~clk;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl),
        .i_sda      (sda_bus),
        .o_sda_oen  (sda_oen),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_busy     (busy),
        .o_err      (err)
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            valid_cnt = valid_cnt + 1;
            valid_run = valid_run + 1;
            if (valid_run > valid_max_run) valid_max_run = valid_run;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end else begin
            valid_run = 0;
        end
        if (err) err_cnt = err_cnt + 1;
        if (sda_oen) oen_cycles = oen_cycles + 1;
        if (busy && !busy_prev) busy_rises = busy_rises + 1;
        busy_prev = busy;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q(); wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b1; wait_q(); wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q();
            scl = 1'b1; wait_q(); wait_q();
            scl = 1'b0; wait_q();
        end
    endtask

    task automatic ack_phase(output logic ack);
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        ack = (sda_bus == 1'b0);
        wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_phase(ack);
    endtask

    task automatic test_reset();
        if (sda_oen !== 1'b0) begin miscompares++; $display("FAIL reset_oen: got %b want 0", sda_oen); end
        vectors++;
        if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", wr_valid); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++;
        if (wr_addr !== 7'h00) begin miscompares++; $display("FAIL reset_addr: got %h want 00", wr_addr); end
        vectors++;
        if (wr_data !== 9'h000) begin miscompares++; $display("FAIL reset_data: got %h want 000", wr_data); end
        vectors++;
        $display("reset: oen=%b valid=%b busy=%b err=%b addr=%h data=%h", sda_oen, wr_valid, busy, err, wr_addr, wr_data);
    endtask

    // Full three-byte write; checks all ACKs and the committed register.
    task automatic test_write(input string name, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [6:0] exp_addr, input logic [8:0] exp_data);
        logic a0, a1, a2;
        int   v0;
        v0 = valid_cnt;
        valid_max_run = 0;
        bus_start();
        if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy_hi: got %b want 1", name, busy); end
        vectors++;
        send_byte(8'h34, a0);
        send_byte(b1, a1);
        send_byte(b2, a2);
        bus_stop();
        if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL %s_acks: got %b want 111", name, {a0, a1, a2}); end
        vectors++;
        if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL %s_strobes: got %0d want 1", name, valid_cnt - v0); end
        vectors++;
        if (valid_max_run !== 1) begin miscompares++; $display("FAIL %s_strobe_width: got %0d want 1", name, valid_max_run); end
        vectors++;
        if (cap_addr !== exp_addr) begin miscompares++; $display("FAIL %s_addr: got %h want %h", name, cap_addr, exp_addr); end
        vectors++;
        if (cap_data !== exp_data) begin miscompares++; $display("FAIL %s_data: got %h want %h", name, cap_data, exp_data); end
        vectors++;
        if (wr_addr !== exp_addr || wr_data !== exp_data) begin
            miscompares++; $display("FAIL %s_held: got %h/%h want %h/%h", name, wr_addr, wr_data, exp_addr, exp_data);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_lo: got %b want 0", name, busy); end
        vectors++;
        $display("write %s: 34 %h %h acks=%b%b%b addr=%h data=%h", name, b1, b2, a0, a1, a2, cap_addr, cap_data);
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int   v0, o0;
        v0 = valid_cnt;
        o0 = oen_cycles;
        bus_start();
        send_byte(8'h36, a0);
        send_byte(8'h35, a1);
        if (busy !== 1'b1) begin miscompares++; $display("FAIL wrong_addr_busy_hi: got %b want 1", busy); end
        vectors++;
        bus_stop();
        if ({a0, a1} !== 2'b00) begin miscompares++; $display("FAIL wrong_addr_acks: got %b want 00", {a0, a1}); end
        vectors++;
        if (oen_cycles - o0 !== 0) begin miscompares++; $display("FAIL wrong_addr_oen: got %0d cycles want 0", oen_cycles - o0); end
        vectors++;
        if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL wrong_addr_strobes: got %0d want 0", valid_cnt - v0); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL wrong_addr_busy_lo: got %b want 0", busy); end
        vectors++;
        $display("wrong addr: 36 35 acks=%b%b oen_cycles=%0d", a0, a1, oen_cycles - o0);
    endtask

    task automatic test_abort();
        logic a0, a1;
        int   v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h1E, a1);
        bus_stop();
        if ({a0, a1} !== 2'b11) begin miscompares++; $display("FAIL abort_acks: got %b want 11", {a0, a1}); end
        vectors++;
        if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL abort_err: got %0d want 1", err_cnt - e0); end
        vectors++;
        if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL abort_strobes: got %0d want 0", valid_cnt - v0); end
        vectors++;
        $display("abort: 34 1E STOP acks=%b%b err_pulses=%0d", a0, a1, err_cnt - e0);
    endtask

    task automatic test_extra_byte();
        logic a0, a1, a2, a3;
        int   v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h0A, a1);
        send_byte(8'h06, a2);
        send_byte(8'hFF, a3);
        bus_stop();
        if ({a0, a1, a2, a3} !== 4'b1110) begin miscompares++; $display("FAIL extra_acks: got %b want 1110", {a0, a1, a2, a3}); end
        vectors++;
        if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL extra_strobes: got %0d want 1", valid_cnt - v0); end
        vectors++;
        if (cap_addr !== 7'h05 || cap_data !== 9'h006) begin
            miscompares++; $display("FAIL extra_commit: got %h/%h want 05/006", cap_addr, cap_data);
        end
        vectors++;
        if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL extra_err: got %0d want 0", err_cnt - e0); end
        vectors++;
        $display("extra byte: 34 0A 06 FF acks=%b%b%b%b addr=%h data=%h", a0, a1, a2, a3, cap_addr, cap_data);
    endtask

    task automatic test_reset_mid_frame();
        logic a0, a1;
        int   v0;
        v0 = valid_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_bits(8'h0A);
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL midrst_ack1_oen: got %b want 1", sda_oen); end
        vectors++;
        #2 rst_n = 1'b0;
        #1;
        if (sda_oen !== 1'b0) begin miscompares++; $display("FAIL midrst_oen_async: got %b want 0", sda_oen); end
        vectors++;
        if (wr_addr !== 7'h00 || wr_data !== 9'h000 || busy !== 1'b0 || err !== 1'b0 || wr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got addr=%h data=%h busy=%b err=%b valid=%b want 00/000/0/0/0",
                     wr_addr, wr_data, busy, err, wr_valid);
        end
        vectors++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_q();
        scl = 1'b0; wait_q();
        bus_stop();
        if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL midrst_strobes: got %0d want 0", valid_cnt - v0); end
        vectors++;
        $display("reset during ACK_1: addr-ack=%b strobes=%0d", a0, valid_cnt - v0);
        a1 = 1'b0;
        test_write("post_reset", 8'h02, 8'h55, 7'h01, 9'h055);
    endtask

    // One-cycle SDA spike while SCL is high.
    task automatic test_spike();
        int b0;
        b0 = busy_rises;
        scl = 1'b1; sda_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        @(negedge clk);
        sda_m = 1'b1;
        wait_q();
`ifdef I2C_RESP_GLITCH_FILTER_EN
        if (busy_rises - b0 !== 0) begin miscompares++; $display("FAIL spike_filtered: got %0d busy rises want 0", busy_rises - b0); end
`else
        if (busy_rises - b0 !== 1) begin miscompares++; $display("FAIL spike_unfiltered: got %0d busy rises want 1", busy_rises - b0); end
`endif
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL spike_busy_end: got %b want 0", busy); end
        vectors++;
        $display("spike: busy rises=%0d", busy_rises - b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        wait_q();
        test_write("w1", 8'h08, 8'h15, 7'h04, 9'h015);
        test_write("w2", 8'h0D, 8'h80, 7'h06, 9'h180);
        test_wrong_addr();
        test_abort();
        test_write("after_abort", 8'h1E, 8'h00, 7'h0F, 9'h000);
        test_extra_byte();
        test_reset_mid_frame();
        test_spike();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
# i2c_codec_responder

Codec-side I2C responder that models the WM8731 control port: it receives the 3-byte register-write frames sent by the I2C initializer and reports each completed write as a one-cycle strobe. It runs on a single system clock, oversamples SCL/SDA, and drives SDA only to acknowledge. It serves as the bus-functional target in the audio recorder's system bench and as the register-write monitor for the codec configuration sequence.

## Interface
- DEV_ADDR, 7'h1A, 7-bit device address that is acknowledged (write byte 0x34).
- i_clk  input  1  system clock; must be at least 8× the SCL frequency.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_scl  input  1  I2C clock from the initiator, asynchronous to i_clk.
- i_sda  input  1  I2C data as seen on the bus, asynchronous to i_clk.
- o_sda_oen  output  1  1 = pull SDA low (ACK); 0 = release.
- o_wr_valid  output  1  one-cycle pulse: a register write is complete.
- o_wr_addr  output  7  register address; valid while o_wr_valid is high, held otherwise.
- o_wr_data  output  9  register data; valid while o_wr_valid is high, held otherwise.
- o_busy  output  1  high from a detected START until the next STOP.
- o_err  output  1  one-cycle pulse: a frame was aborted after its address was acknowledged.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer. Edges are detected on the synchronized values.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge, MSB first.
- Frame format: [DEV_ADDR, R/W] → ACK → [reg[6:0], data[8]] → ACK → [data[7:0]] → ACK → STOP.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits with a 3-bit counter (0–7).
    - Address matches and R/W = 0 → ACK_A.
    - Otherwise → IGNORE; no ACK is driven.
  - ACK_A, ACK_1, ACK_2 each assert o_sda_oen from the SCL falling edge after bit 8 until the next SCL falling edge.
  - ACK_A → BYTE1 → ACK_1 → BYTE2 → ACK_2.
  - On the SCL falling edge that ends ACK_2, pulse o_wr_valid and update o_wr_addr/o_wr_data, then → IGNORE.
  - IGNORE: any further bytes get no ACK; wait for START or STOP.
- START in any state (repeated START): discard the partial frame and go to ADDR. STOP in any state: go to IDLE.
- o_err pulses if START or STOP arrives in BYTE1, ACK_1, BYTE2 or ACK_2, i.e. after an address ACK but before the commit. No o_err in ADDR or IGNORE.
- Reset values:
  - state IDLE; o_sda_oen, o_wr_valid, o_busy, o_err = 0; o_wr_addr = 0; o_wr_data = 0.
  - Synchronizer flops reset to 1 (idle bus).

## Timing
- Latency from a pin edge to the internal detected event is 3 i_clk cycles (2 sync + 1 edge register); add 2 cycles with the glitch filter.
- o_sda_oen changes in the same cycle the SCL falling edge is detected.
- o_wr_valid asserts on that same cycle at the end of ACK_2 and is high for exactly 1 cycle.
- o_busy rises the cycle START is detected and falls the cycle STOP is detected.
- Simultaneous events:
  - START or STOP takes priority over data sampling in the same cycle.
  - An SDA change while SCL is high is never sampled as data.
- Reset mid-frame releases SDA immediately (asynchronous) and produces no strobe. After reset the responder waits for a fresh START.

## Configuration
- I2C_RESP_GLITCH_FILTER_EN
  - Defined: after the synchronizer, each of SCL and SDA goes through a 3-sample majority filter. Single-cycle spikes are rejected; detection latency becomes 5 cycles.
  - Undefined: no filter; 3-cycle latency; a 1-cycle spike is treated as a real edge.

## Test plan
- Frame 0x34, 0x08, 0x15, STOP → ACK on all 3 bytes; o_wr_valid for 1 cycle with o_wr_addr = 0x04, o_wr_data = 0x015.
- Frame 0x34, 0x0D, 0x80 → o_wr_addr = 0x06, o_wr_data = 0x180.
- Address byte 0x36, then byte 0x35 → o_sda_oen stays 0 throughout; no o_wr_valid; o_busy falls at STOP.
- 0x34, 0x1E, then STOP → ACK on 2 bytes; o_err pulses once; no o_wr_valid. A following valid frame 0x34, 0x1E, 0x00 → addr 0x0F, data 0x000.
- 0x34, 0x0A, 0x06, then extra byte 0xFF → first write commits (addr 0x05, data 0x006); 0xFF gets no ACK.
- i_rst_n pulsed low during ACK_1 → o_sda_oen = 0 immediately; all outputs at reset values; next full frame works. With the filter macro defined, a 1-cycle SDA spike while SCL is high produces no START/STOP.
